// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one UART transmitter between NUM_REQ
// byte-stream requesters. The owner sends a burst of up to MAX_BURST bytes,
// one start pulse per byte, with each byte handshaked through the
// transmitter busy flag. After each burst the grant is held idle for
// GAP_TICKS bit periods, counted from the baud generator tick toggle,
// before arbitration runs again.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   i_Req         per-requester "valid byte on lane" flags
//   i_Data        flattened byte lanes, lane i = [i*DATA_WIDTH +: DATA_WIDTH]
//   i_Last        per-requester "current byte ends the packet" flags
//   o_Ack         one-cycle pulse: byte on the granted lane consumed
//   o_Grant       one-hot current owner, zero when idle
//   o_Tx_Data     byte to the transmitter
//   o_Tx_Start    one-cycle start pulse to the transmitter
//   i_Tx_Busy     transmitter frame in progress
//   i_Tx_ClkTick  tick toggle from the baud generator (two toggles per bit)
//   o_Busy        high in every state except IDLE
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int GAP_TICKS  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            i_Req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_Data,
    input  logic [NUM_REQ-1:0]            i_Last,
    output logic [NUM_REQ-1:0]            o_Ack,
    output logic [NUM_REQ-1:0]            o_Grant,
    output logic [DATA_WIDTH-1:0]         o_Tx_Data,
    output logic                          o_Tx_Start,
    input  logic                          i_Tx_Busy,
    input  logic                          i_Tx_ClkTick,
    output logic                          o_Busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int BC_W  = $clog2(MAX_BURST + 1);
    localparam int GC_W  = (GAP_TICKS < 1) ? 1 : $clog2(GAP_TICKS + 1);

    localparam logic [PTR_W-1:0] PTR_RESET   = PTR_W'(NUM_REQ - 1);
    localparam logic [BC_W-1:0]  BURST_LIMIT = BC_W'(MAX_BURST);
    localparam logic [GC_W-1:0]  GAP_LIMIT   = GC_W'(GAP_TICKS);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [BC_W-1:0]   burst_cnt;
    logic [GC_W-1:0]   gap_cnt;
    logic              last_q;
    logic              tick_d;
    logic              bit_edge;
    logic              win_found;
    logic [PTR_W-1:0]  win_idx;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // The tick toggles twice per bit, so its rising edge marks one bit period.
    assign bit_edge = i_Tx_ClkTick & ~tick_d;
    assign o_Busy   = (state != IDLE);

    // Round-robin search: start just after the last owner and wrap, so the
    // previous owner is the lowest priority candidate.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && i_Req[(int'(ptr) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    // Main FSM. ptr doubles as the index of the current owner while granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= PTR_RESET;
            burst_cnt  <= '0;
            gap_cnt    <= '0;
            last_q     <= 1'b0;
            tick_d     <= 1'b0;
            o_Ack      <= '0;
            o_Grant    <= '0;
            o_Tx_Data  <= '0;
            o_Tx_Start <= 1'b0;
        end else begin
            tick_d     <= i_Tx_ClkTick;
            o_Tx_Start <= 1'b0;
            o_Ack      <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        o_Grant   <= onehot(win_idx);
                        ptr       <= win_idx;
                        burst_cnt <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    o_Tx_Data  <= i_Data[int'(ptr)*DATA_WIDTH +: DATA_WIDTH];
                    o_Tx_Start <= 1'b1;
                    o_Ack      <= onehot(ptr);
                    last_q     <= i_Last[ptr];
                    burst_cnt  <= burst_cnt + BC_W'(1);
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (i_Tx_Busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!i_Tx_Busy) begin
                        if (last_q || (burst_cnt == BURST_LIMIT) || !i_Req[ptr]) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                GAP: begin
                    if (GAP_TICKS == 0) begin
                        o_Grant <= '0;
                        state   <= IDLE;
                    end else if (bit_edge) begin
                        gap_cnt <= gap_cnt + GC_W'(1);
                        if ((gap_cnt + GC_W'(1)) == GAP_LIMIT) begin
                            o_Grant <= '0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter. A byte-source model per lane feeds the
// default build, a bus model emulates the transmitter busy flag (rises 2
// cycles after start, held 10 cycles), and a monitor logs every start pulse.
// A second build with GAP_TICKS = 0 and two requesters is driven by hand.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        tx_tick = 1'b0;
    logic        busy;

    logic [1:0]  r2_req;
    logic [15:0] r2_data;
    logic [1:0]  r2_last;
    logic [1:0]  r2_ack;
    logic [1:0]  r2_grant;
    logic [7:0]  r2_tx_data;
    logic        r2_start;
    logic        r2_tx_busy;
    logic        r2_busy;

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter dut (
        .clk(clk), .reset(reset), .i_Req(req), .i_Data(data), .i_Last(last),
        .o_Ack(ack), .o_Grant(grant), .o_Tx_Data(tx_data), .o_Tx_Start(tx_start),
        .i_Tx_Busy(tx_busy), .i_Tx_ClkTick(tx_tick), .o_Busy(busy)
    );

    uart_tx_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(4), .GAP_TICKS(0)) dut_nogap (
        .clk(clk), .reset(reset), .i_Req(r2_req), .i_Data(r2_data), .i_Last(r2_last),
        .o_Ack(r2_ack), .o_Grant(r2_grant), .o_Tx_Data(r2_tx_data), .o_Tx_Start(r2_start),
        .i_Tx_Busy(r2_tx_busy), .i_Tx_ClkTick(1'b0), .o_Busy(r2_busy)
    );

    always #5 clk = ~clk;

    // Tick toggles every 4 clocks (8-clock bit period), offset from both edges.
    initial begin
        #2;
        forever #40 tx_tick = ~tx_tick;
    end

    // Byte-source model: each lane walks through its table, advancing on ack.
    logic [7:0] src_byte  [4][8];
    bit         src_lastb [4][8];
    int         src_len [4];
    int         src_pos [4];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) src_pos[i]++;
            if (src_pos[i] < src_len[i]) begin
                req[i]        = 1'b1;
                data[i*8 +: 8] = src_byte[i][src_pos[i]];
                last[i]       = src_lastb[i][src_pos[i]];
            end else begin
                req[i]        = 1'b0;
                data[i*8 +: 8] = 8'h00;
                last[i]       = 1'b0;
            end
        end
    end

    // Transmitter bus model plus start/ack monitor.
    bit         bus_en = 1'b1;
    int         bus_t = -1;
    int         overlap_cnt = 0;
    int         ack_bad = 0;
    int         ack_total = 0;
    logic [7:0] log_data  [$];
    logic [3:0] log_grant [$];

    always @(negedge clk) begin
        if (((ack & ~grant) != 4'b0) || ((ack != 4'b0) != tx_start)) ack_bad++;
        if (ack != 4'b0) ack_total++;
        if (tx_start) begin
            if (bus_t >= 0) overlap_cnt++;
            log_data.push_back(tx_data);
            log_grant.push_back(grant);
            if (bus_en) bus_t = 0;
        end else if (bus_t >= 0) begin
            bus_t++;
        end
        if (bus_t >= 12) bus_t = -1;
        tx_busy = (bus_t >= 2);
    end

    function automatic int lane_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g == (4'b0001 << i)) return i;
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < 4; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_sources();
        bus_t  = -1;
        bus_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        log_data.delete();
        log_grant.delete();
        overlap_cnt = 0;
        ack_bad     = 0;
        ack_total   = 0;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget, output bit ok);
        bit done;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            step();
            done = !busy;
            for (int i = 0; i < 4; i++) if (src_pos[i] < src_len[i]) done = 1'b0;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Follows one frame through busy high/low, then counts bit edges seen
    // while the grant is still held in the gap.
    task automatic frame_and_gap(output bit ok, output logic [3:0] gap_grant, output int edges);
        int   c;
        logic prev;
        ok = 1'b0; edges = 0; gap_grant = 4'b0; c = 0;
        while (!tx_busy && c < 20) begin step(); c++; end
        while (tx_busy && c < 40) begin step(); c++; end
        if (c >= 40) return;
        step();
        gap_grant = grant;
        prev = tx_tick;
        for (int k = 0; k < 60; k++) begin
            step();
            if (tx_tick && !prev) edges++;
            prev = tx_tick;
            if (grant == 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        step();
        checks++; if (grant !== 4'b0) begin failures++; $display("[TB] FAIL reset_grant actual=%b expected=0000", grant); end
        checks++; if (ack !== 4'b0) begin failures++; $display("[TB] FAIL reset_ack actual=%b expected=0000", ack); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_start actual=%b expected=0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_txdata actual=%h expected=00", tx_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy actual=%b expected=0", busy); end
        do_reset();
    endtask

    task automatic test_single();
        bit         ok;
        logic [3:0] gg;
        int         edges;
        src_byte[1][0] = 8'h55; src_lastb[1][0] = 1'b1; src_len[1] = 1;
        step();
        step();
        checks++; if (grant !== 4'b0010) begin failures++; $display("[TB] FAIL single_grant actual=%b expected=0010", grant); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("[TB] FAIL single_start_early actual=%b expected=0", tx_start); end
        step();
        checks++; if (tx_start !== 1'b1) begin failures++; $display("[TB] FAIL single_start actual=%b expected=1", tx_start); end
        checks++; if (tx_data !== 8'h55) begin failures++; $display("[TB] FAIL single_data actual=%h expected=55", tx_data); end
        checks++; if (ack !== 4'b0010) begin failures++; $display("[TB] FAIL single_ack actual=%b expected=0010", ack); end
        frame_and_gap(ok, gg, edges);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL single_timeout actual=%0d expected=1", ok); end
        checks++; if (gg !== 4'b0010) begin failures++; $display("[TB] FAIL single_gap_grant actual=%b expected=0010", gg); end
        checks++; if (edges != 2) begin failures++; $display("[TB] FAIL single_gap_edges actual=%0d expected=2", edges); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_end_busy actual=%b expected=0", busy); end
        checks++; if (log_data.size() != 1) begin failures++; $display("[TB] FAIL single_starts actual=%0d expected=1", log_data.size()); end
        checks++; if (ack_total != 1) begin failures++; $display("[TB] FAIL single_acks actual=%0d expected=1", ack_total); end
    endtask

    task automatic test_all_four();
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src_byte[i][0] = 8'hA0 + 8'(i); src_lastb[i][0] = 1'b1;
            src_byte[i][1] = 8'hB0 + 8'(i); src_lastb[i][1] = 1'b1;
            src_len[i] = 2;
        end
        drain(800, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL four_timeout actual=%0d expected=1", ok); end
        checks++; if (log_data.size() != 8) begin failures++; $display("[TB] FAIL four_count actual=%0d expected=8", log_data.size()); end
        for (int k = 0; k < 8 && k < log_data.size(); k++) begin
            logic [7:0] exp_d;
            exp_d = (k < 4) ? (8'hA0 + 8'(k)) : (8'hB0 + 8'(k - 4));
            checks++; if (log_data[k] !== exp_d) begin failures++; $display("[TB] FAIL four_data%0d actual=%h expected=%h", k, log_data[k], exp_d); end
            checks++; if (lane_of(log_grant[k]) != k % 4) begin failures++; $display("[TB] FAIL four_lane%0d actual=%0d expected=%0d", k, lane_of(log_grant[k]), k % 4); end
        end
        checks++; if (overlap_cnt != 0) begin failures++; $display("[TB] FAIL four_overlap actual=%0d expected=0", overlap_cnt); end
        checks++; if (ack_bad != 0) begin failures++; $display("[TB] FAIL four_ack_lane actual=%0d expected=0", ack_bad); end
    endtask

    task automatic test_burst_limit();
        bit         ok;
        logic [7:0] exp_d [7];
        int         exp_l [7];
        exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h33, 8'h14, 8'h15};
        exp_l = '{2, 2, 2, 2, 3, 2, 2};
        do_reset();
        for (int j = 0; j < 6; j++) begin
            src_byte[2][j] = 8'h10 + 8'(j);
            src_lastb[2][j] = (j == 5);
        end
        src_len[2] = 6;
        src_byte[3][0] = 8'h33; src_lastb[3][0] = 1'b1; src_len[3] = 1;
        drain(800, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL burst_timeout actual=%0d expected=1", ok); end
        checks++; if (log_data.size() != 7) begin failures++; $display("[TB] FAIL burst_count actual=%0d expected=7", log_data.size()); end
        for (int k = 0; k < 7 && k < log_data.size(); k++) begin
            checks++; if (log_data[k] !== exp_d[k]) begin failures++; $display("[TB] FAIL burst_data%0d actual=%h expected=%h", k, log_data[k], exp_d[k]); end
            checks++; if (lane_of(log_grant[k]) != exp_l[k]) begin failures++; $display("[TB] FAIL burst_lane%0d actual=%0d expected=%0d", k, lane_of(log_grant[k]), exp_l[k]); end
        end
    endtask

    task automatic test_drop_req();
        bit         ok;
        logic [3:0] gg;
        int         edges;
        do_reset();
        src_byte[1][0] = 8'h5A; src_lastb[1][0] = 1'b0; src_len[1] = 1;
        step();
        step();
        step();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h5A) begin failures++; $display("[TB] FAIL drop_first actual=%b/%h expected=1/5a", tx_start, tx_data); end
        frame_and_gap(ok, gg, edges);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL drop_timeout actual=%0d expected=1", ok); end
        checks++; if (gg !== 4'b0010) begin failures++; $display("[TB] FAIL drop_gap_grant actual=%b expected=0010", gg); end
        checks++; if (edges != 2) begin failures++; $display("[TB] FAIL drop_gap_edges actual=%0d expected=2", edges); end
        repeat (10) step();
        checks++; if (ack_total != 1) begin failures++; $display("[TB] FAIL drop_acks actual=%0d expected=1", ack_total); end
        checks++; if (log_data.size() != 1) begin failures++; $display("[TB] FAIL drop_starts actual=%0d expected=1", log_data.size()); end
    endtask

    task automatic test_stuck_busy();
        bit ok;
        do_reset();
        bus_en = 1'b0;
        src_byte[2][0] = 8'h77; src_lastb[2][0] = 1'b1; src_len[2] = 1;
        repeat (30) step();
        checks++; if (log_data.size() != 1) begin failures++; $display("[TB] FAIL stuck_starts actual=%0d expected=1", log_data.size()); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL stuck_busy actual=%b expected=1", busy); end
        checks++; if (grant !== 4'b0100) begin failures++; $display("[TB] FAIL stuck_grant actual=%b expected=0100", grant); end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++; if (grant !== 4'b0 || ack !== 4'b0) begin failures++; $display("[TB] FAIL stuck_rst_grant_ack actual=%b/%b expected=0000/0000", grant, ack); end
        checks++; if (tx_start !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin failures++; $display("[TB] FAIL stuck_rst_outs actual=%b/%b/%h expected=0/0/00", tx_start, busy, tx_data); end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src_byte[i][0] = 8'hC0 + 8'(i); src_lastb[i][0] = 1'b1;
            src_len[i] = (i == 2) ? 0 : 1;
        end
        drain(400, ok);
        checks++; if (!ok || log_data.size() != 3) begin failures++; $display("[TB] FAIL stuck_rearb actual=%0d/%0d expected=1/3", ok, log_data.size()); end
        if (log_data.size() > 0) begin
            checks++; if (lane_of(log_grant[0]) != 0 || log_data[0] !== 8'hC0) begin failures++; $display("[TB] FAIL stuck_first_owner actual=%0d/%h expected=0/c0", lane_of(log_grant[0]), log_data[0]); end
        end
    endtask

    task automatic test_no_gap();
        int k;
        r2_data = {8'hD1, 8'hD0}; r2_last = 2'b11; r2_tx_busy = 1'b0; r2_req = 2'b11;
        k = 0;
        while (!r2_start && k < 10) begin step(); k++; end
        checks++; if (r2_start !== 1'b1 || r2_tx_data !== 8'hD0 || r2_grant !== 2'b01) begin failures++; $display("[TB] FAIL nogap_first actual=%b/%h/%b expected=1/d0/01", r2_start, r2_tx_data, r2_grant); end
        r2_req[0] = 1'b0;
        step();
        r2_tx_busy = 1'b1;
        repeat (5) step();
        r2_tx_busy = 1'b0;
        k = 0;
        while (!r2_start && k < 12) begin step(); k++; end
        checks++; if (!r2_start || (k - 1) > 3) begin failures++; $display("[TB] FAIL nogap_latency actual=%0d expected<=3", k - 1); end
        checks++; if (r2_tx_data !== 8'hD1 || r2_grant !== 2'b10) begin failures++; $display("[TB] FAIL nogap_second actual=%h/%b expected=d1/10", r2_tx_data, r2_grant); end
        r2_req = 2'b00;
    endtask

    initial begin
        reset = 1'b1;
        req = '0; data = '0; last = '0;
        r2_req = '0; r2_data = '0; r2_last = '0; r2_tx_busy = 1'b0;
        clear_sources();
        test_reset();
        test_single();
        test_all_four();
        test_burst_limit();
        test_drop_req();
        test_stuck_busy();
        test_no_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
